// File: rtl/param_nonrestoring_divider.sv
// Iterative radix-2 nonrestoring integer divider for the EX-stage multicycle
// unit. Runs DIV/DIVU/REM/REMU with RISC-V corner-case semantics. Operands are
// leading-zero normalised so only the iterations that can produce quotient
// bits do real work; with EARLY_TERM=0 the unit pads to a fixed XLEN
// iterations.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid & in_ready & ~flush_ex; in_ready is high only in IDLE. out_valid
// is a single-cycle pulse in DONE (masked by flush_ex) and quo/rem/result
// are valid during that pulse. Afterwards they hold that value until the next
// operation completes.
module param_nonrestoring_divider #(
    parameter int XLEN       = 32,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush_ex,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;   // holds 0..XLEN
    localparam int PW = XLEN + 2;           // signed partial remainder
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_ITER = 3'd2,
        S_CORR = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Count of leading zeros; an all-zero value yields XLEN.
    function automatic logic [CW-1:0] lz_f(input logic [XLEN-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + CW'(1);
            end
        end
        return n;
    endfunction

    state_t state_q, state_d;

    // Operation registers captured on accept
    logic [1:0]      f3_q, f3_d;          // [0]=unsigned, [1]=remainder
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;

    // Iteration datapath
    logic [XLEN-1:0] b_n_q, b_n_d;        // left-aligned |b|
    logic [CW-1:0]   lzb_q, lzb_d;        // alignment shift of |b|
    logic [PW-1:0]   p_q, p_d;            // partial remainder (two's complement)
    logic [XLEN-1:0] q_q, q_d;            // quotient magnitude being built
    logic [CW-1:0]   cnt_q, cnt_d;        // iterations remaining
    logic [CW-1:0]   work_q, work_d;      // iterations that do real work

    // Result of the operation in flight (shown only in DONE)
    logic [XLEN-1:0] quo_p_q, quo_p_d;
    logic [XLEN-1:0] rem_p_q, rem_p_d;

    // Last completed result, held between operations
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] res_q, res_d;

    // funct3[2] is always 1 for the divide group and carries no information
    logic unused_f3;
    assign unused_f3 = funct3[2];

    logic            accept;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [CW-1:0]   lza, lzb, span;
    logic            is_div0, is_ovf, is_lt, special;
    logic [PW-1:0]   b_ext, t_sum;
    logic            iter_active, iter_last;
    logic [XLEN-1:0] rem_lo, rem_mag;
    logic            show_pending;
    logic [XLEN-1:0] res_pending;

    assign accept = in_valid & (state_q == S_IDLE) & ~flush_ex;

    // Operand decode used in NORM: magnitudes, alignment and special cases
    always_comb begin
        abs_a   = sa_q ? (~a_q + XLEN'(1)) : a_q;
        abs_b   = sb_q ? (~b_q + XLEN'(1)) : b_q;
        lza     = lz_f(abs_a);
        lzb     = lz_f(abs_b);
        span    = lzb - lza + CW'(1);
        is_div0 = (b_q == '0);
        is_ovf  = ~f3_q[0] & (a_q == MIN_VAL) & (b_q == '1);
        is_lt   = (abs_a < abs_b);
        special = is_div0 | is_ovf | is_lt;
    end

    // One nonrestoring step and the final remainder fix-up
    always_comb begin
        b_ext       = {2'b00, b_n_q};
        t_sum       = p_q[PW-1] ? (p_q + b_ext) : (p_q - b_ext);
        iter_active = (cnt_q <= work_q);
        iter_last   = (cnt_q == CW'(1));
        // The corrected remainder is below the aligned divisor, so the low
        // XLEN bits of the add are exact.
        rem_lo      = p_q[PW-1] ? (p_q[XLEN-1:0] + b_n_q) : p_q[XLEN-1:0];
        rem_mag     = rem_lo >> lzb_q;
    end

    // Next-state logic; a flush sends any busy state straight back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_NORM;
            S_NORM: state_d = special ? S_DONE : S_ITER;
            S_ITER: if (iter_last) state_d = S_CORR;
            S_CORR: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_ex && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // Datapath register updates per state
    always_comb begin
        f3_d    = f3_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        b_n_d   = b_n_q;
        lzb_d   = lzb_q;
        p_d     = p_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        quo_p_d = quo_p_q;
        rem_p_d = rem_p_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d = funct3[1:0];
                    a_d  = a;
                    b_d  = b;
                    sa_d = a[XLEN-1] & ~funct3[0];
                    sb_d = b[XLEN-1] & ~funct3[0];
                end
            end
            S_NORM: begin
                if (is_div0) begin
                    quo_p_d = '1;
                    rem_p_d = a_q;
                end else if (is_ovf) begin
                    quo_p_d = MIN_VAL;
                    rem_p_d = '0;
                end else if (is_lt) begin
                    // also covers a == 0
                    quo_p_d = '0;
                    rem_p_d = a_q;
                end else begin
                    b_n_d  = abs_b << lzb;
                    lzb_d  = lzb;
                    p_d    = {2'b00, abs_a << lza};
                    q_d    = '0;
                    cnt_d  = EARLY_TERM ? span : CW'(XLEN);
                    work_d = span;
                end
            end
            S_ITER: begin
                // In fixed-latency mode the leading padding cycles only count.
                // The last step keeps the unshifted value, which is the
                // remainder scaled by the divisor alignment.
                if (iter_active) begin
                    p_d = iter_last ? t_sum : (t_sum << 1);
                    q_d = {q_q[XLEN-2:0], ~t_sum[PW-1]};
                end
                cnt_d = cnt_q - CW'(1);
            end
            S_CORR: begin
                // Each quotient bit is ~sign of the new partial remainder, which
                // equals the restoring quotient bit, so only the remainder needs
                // the add-back when it ended negative.
                quo_p_d = (sa_q ^ sb_q) ? (~q_q + XLEN'(1)) : q_q;
                rem_p_d = sa_q ? (~rem_mag + XLEN'(1)) : rem_mag;
            end
            S_DONE: begin
                if (!flush_ex) begin
                    quo_d = quo_p_q;
                    rem_d = rem_p_q;
                    res_d = f3_q[1] ? rem_p_q : quo_p_q;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            b_n_q   <= '0;
            lzb_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            quo_p_q <= '0;
            rem_p_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            b_n_q   <= b_n_d;
            lzb_q   <= lzb_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            quo_p_q <= quo_p_d;
            rem_p_q <= rem_p_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end

    // Outputs: the in-flight result during the DONE pulse, else the last one
    always_comb begin
        show_pending = (state_q == S_DONE) & ~flush_ex;
        res_pending  = f3_q[1] ? rem_p_q : quo_p_q;
        in_ready     = (state_q == S_IDLE);
        out_valid    = show_pending;
        quo          = show_pending ? quo_p_q : quo_q;
        rem          = show_pending ? rem_p_q : rem_q;
        result       = show_pending ? res_pending : res_q;
    end

endmodule

// File: tb/tb_param_nonrestoring_divider.sv
// Self-checking bench for param_nonrestoring_divider: directed corner cases,
// randomized operands against an arithmetic reference, flush, reset and
// back-to-back handshake scenarios.
module tb_param_nonrestoring_divider;

  localparam int XLEN = 32;
  localparam bit ET   = 1'b1;
  localparam int BOUND = 200;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
  } dcase_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic            flush_ex;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            out_valid;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  logic [31:0] last_res = '0;

  param_nonrestoring_divider #(.XLEN(XLEN), .EARLY_TERM(ET)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush_ex (flush_ex),
    .funct3   (funct3),
    .a        (a_in),
    .b        (b_in),
    .out_valid(out_valid),
    .quo      (quo),
    .rem      (rem),
    .result   (result)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int bitlen(input longint v);
    int n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  // RISC-V divide semantics with plain 64-bit arithmetic; latency is 2 for
  // the special cases, otherwise iteration count + 3.
  function automatic void ref_div(input logic [2:0] f3, input logic [31:0] av,
                                  input logic [31:0] bv, output logic [31:0] q,
                                  output logic [31:0] r, output logic [31:0] res,
                                  output int lat);
    longint sa, sb, ma, mb;
    if (f3[0]) begin
      sa = longint'({32'd0, av});
      sb = longint'({32'd0, bv});
    end else begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (bv == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = av;
      lat = 2;
    end else if (!f3[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
      lat = 2;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      if (ma < mb) lat = 2;
      else lat = (ET ? (bitlen(ma) - bitlen(mb) + 1) : XLEN) + 3;
    end
    res = f3[1] ? r : q;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_op: in_ready=%0b after %0d cycles, required 1", in_ready, w);
    end
    funct3   = f3;
    a_in     = av;
    b_in     = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                       output int lat, output logic [31:0] q, output logic [31:0] r,
                       output logic [31:0] res, output bit timed_out);
    start_op(f3, av, bv);
    lat = 0;
    timed_out = 1'b1;
    q = '0;
    r = '0;
    res = '0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        q = quo;
        r = rem;
        res = result;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush_ex = 1'b0;
    funct3   = 3'b100;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (quo !== 32'd0) begin n_fail++; $display("FAIL reset_quo: got %h want 0", quo); end
    n_checks++; if (rem !== 32'd0) begin n_fail++; $display("FAIL reset_rem: got %h want 0", rem); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
  endtask

  task automatic test_directed();
    dcase_t tbl [0:11];
    logic [31:0] q, r, res, mq, mr, mres;
    int lat, mlat;
    bit to;
    tbl[0]  = '{3'b100, 32'd100,        32'd7,          32'd14,         32'd2};
    tbl[1]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[2]  = '{3'b111, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'h0000_000F};
    tbl[3]  = '{3'b101, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234};
    tbl[4]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[6]  = '{3'b101, 32'd0,          32'd5,          32'd0,          32'd0};
    tbl[7]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    tbl[8]  = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    tbl[9]  = '{3'b100, 32'd3,          32'hFFFF_FFFB,  32'd0,          32'd3};
    tbl[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    tbl[11] = '{3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    for (int i = 0; i < 12; i++) begin
      ref_div(tbl[i].f3, tbl[i].a, tbl[i].b, mq, mr, mres, mlat);
      do_op(tbl[i].f3, tbl[i].a, tbl[i].b, lat, q, r, res, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL dir%0d_timeout: no out_valid within %0d cycles", i, BOUND); end
      n_checks++; if (q !== tbl[i].eq) begin n_fail++; $display("FAIL dir%0d_quo: got %h want %h", i, q, tbl[i].eq); end
      n_checks++; if (r !== tbl[i].er) begin n_fail++; $display("FAIL dir%0d_rem: got %h want %h", i, r, tbl[i].er); end
      n_checks++;
      if (res !== (tbl[i].f3[1] ? tbl[i].er : tbl[i].eq)) begin
        n_fail++; $display("FAIL dir%0d_result: got %h want %h", i, res, tbl[i].f3[1] ? tbl[i].er : tbl[i].eq);
      end
      n_checks++; if (lat != mlat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, mlat); end
      last_q = tbl[i].eq; last_r = tbl[i].er; last_res = tbl[i].f3[1] ? tbl[i].er : tbl[i].eq;
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] av, bv, q, r, res, mq, mr, mres;
    int lat, mlat;
    bit to;
    for (int i = 0; i < 400; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      av = $urandom >> $urandom_range(0, 31);
      bv = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) av = -av;
      if ($urandom_range(0, 1) == 1) bv = -bv;
      if ($urandom_range(0, 15) == 0) bv = 32'd0;
      if ($urandom_range(0, 31) == 0) begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
      ref_div(f3, av, bv, mq, mr, mres, mlat);
      do_op(f3, av, bv, lat, q, r, res, to);
      n_checks++;
      if (to || q !== mq || r !== mr || res !== mres) begin
        n_fail++;
        $display("FAIL rand%0d_value: f3=%b a=%h b=%h got q=%h r=%h res=%h want q=%h r=%h res=%h",
                 i, f3, av, bv, q, r, res, mq, mr, mres);
      end
      n_checks++;
      if (lat != mlat) begin
        n_fail++; $display("FAIL rand%0d_latency: f3=%b a=%h b=%h got %0d want %0d", i, f3, av, bv, lat, mlat);
      end
      last_q = mq; last_r = mr; last_res = mres;
    end
  endtask

  task automatic test_flush_iter();
    logic [31:0] q, r, res, mq, mr, mres;
    int lat, mlat, pulses;
    bit to;
    // establish a known completed value
    ref_div(3'b101, 32'd1234, 32'd10, mq, mr, mres, mlat);
    do_op(3'b101, 32'd1234, 32'd10, lat, q, r, res, to);
    n_checks++; if (q !== 32'd123) begin n_fail++; $display("FAIL flush_pre_quo: got %h want %h", q, 32'd123); end
    last_q = mq; last_r = mr; last_res = mres;
    // 32-iteration op, flushed three cycles in
    start_op(3'b101, 32'hFFFF_FFFF, 32'd1);
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_busy_ready: got %0b want 0", in_ready); end
    flush_ex = 1'b1;
    @(posedge clk);
    #1 flush_ex = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", in_ready); end
    n_checks++; if (quo !== last_q) begin n_fail++; $display("FAIL flush_hold_quo: got %h want %h", quo, last_q); end
    n_checks++; if (rem !== last_r) begin n_fail++; $display("FAIL flush_hold_rem: got %h want %h", rem, last_r); end
    n_checks++; if (result !== last_res) begin n_fail++; $display("FAIL flush_hold_result: got %h want %h", result, last_res); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL flush_no_valid: got %0d pulses want 0", pulses); end
    // new op after the flush
    ref_div(3'b100, 32'hFFFF_FF9C, 32'd7, mq, mr, mres, mlat);
    do_op(3'b100, 32'hFFFF_FF9C, 32'd7, lat, q, r, res, to);
    n_checks++;
    if (to || q !== mq || r !== mr || res !== mres || lat != mlat) begin
      n_fail++; $display("FAIL flush_next_op: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", q, r, lat, mq, mr, mlat);
    end
    last_q = mq; last_r = mr; last_res = mres;
  endtask

  task automatic test_flush_done();
    logic [31:0] mq, mr, mres;
    int mlat;
    ref_div(3'b100, 32'd100, 32'd7, mq, mr, mres, mlat);
    start_op(3'b100, 32'd100, 32'd7);
    repeat (mlat) @(negedge clk);
    flush_ex = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done_valid: got %0b want 0", out_valid); end
    n_checks++; if (quo !== last_q) begin n_fail++; $display("FAIL flush_done_quo: got %h want %h", quo, last_q); end
    @(posedge clk);
    #1 flush_ex = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_done_ready: got %0b want 1", in_ready); end
    n_checks++; if (rem !== last_r) begin n_fail++; $display("FAIL flush_done_rem: got %h want %h", rem, last_r); end
    n_checks++; if (result !== last_res) begin n_fail++; $display("FAIL flush_done_result: got %h want %h", result, last_res); end
  endtask

  task automatic test_flush_idle();
    int pulses = 0;
    @(negedge clk);
    funct3 = 3'b101; a_in = 32'd50; b_in = 32'd3;
    in_valid = 1'b1;
    flush_ex = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush_ex = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready: got %0b want 1", in_ready); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL flush_idle_no_valid: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    op_t ops [0:7];
    logic [95:0] exp_q[$];
    logic [95:0] e;
    logic [31:0] mq, mr, mres;
    int mlat, acc, got, cyc, done_cyc;
    for (int i = 0; i < 8; i++) begin
      ops[i].f3 = 3'b100 | 3'($urandom_range(0, 3));
      ops[i].a  = $urandom >> $urandom_range(0, 20);
      ops[i].b  = $urandom >> $urandom_range(8, 31);
      if (i == 3) ops[i].b = 32'd0;
    end
    acc = 0; got = 0; cyc = 0; done_cyc = -10;
    @(negedge clk);
    while (got < 8 && cyc < 2000) begin
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: out_valid with empty queue at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({quo, rem, result} !== e) begin
            n_fail++; $display("FAIL b2b_value%0d: got %h %h %h want %h %h %h", got, quo, rem, result,
                               e[95:64], e[63:32], e[31:0]);
          end
        end
        got++;
        done_cyc = cyc;
      end
      if (in_ready) begin
        if (acc < 8) begin
          if (acc > 0) begin
            n_checks++;
            if (cyc != done_cyc + 1) begin
              n_fail++; $display("FAIL b2b_accept_timing%0d: got cycle %0d want %0d", acc, cyc, done_cyc + 1);
            end
          end
          funct3 = ops[acc].f3; a_in = ops[acc].a; b_in = ops[acc].b;
          in_valid = 1'b1;
          ref_div(ops[acc].f3, ops[acc].a, ops[acc].b, mq, mr, mres, mlat);
          exp_q.push_back({mq, mr, mres});
          last_q = mq; last_r = mr; last_res = mres;
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d results want 8", got); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    start_op(3'b101, 32'hFFFF_FFFF, 32'd1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (quo !== 32'd0) begin n_fail++; $display("FAIL rst_mid_quo: got %h want 0", quo); end
    n_checks++; if (rem !== 32'd0) begin n_fail++; $display("FAIL rst_mid_rem: got %h want 0", rem); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", result); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %0b want 1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", pulses); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush_iter();
    test_flush_done();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
